sar_search_ctrl: RTL
====================

# sar_search_ctrl

Successive-approximation search controller: the initiator side of the magnitude-comparator interface. It drives a trial value into an external equal/less/greater comparator, consumes the one-hot verdict, and converges MSB-first on an unknown target. Used wherever a threshold or code must be found by binary search against a comparator, for example SAR-ADC style loops and table threshold search.

## Interface
- WIDTH, 8, width of trial/result; must be ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin search; honoured only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE, no done pulse
- trial  out  WIDTH  registered value presented to comparator (comparator a input)
- cmp_valid  in  1  comparator verdict valid this cycle
- cmp_lt  in  1  trial < target
- cmp_eq  in  1  trial == target
- cmp_gt  in  1  trial > target
- busy  out  1  high from accepted start until done/abort
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  converged value; held until next accepted start
- found  out  1  an exact-match verdict (cmp_eq) ended the search
- err  out  1  the search ended on a non-one-hot verdict

## Operation
- States: IDLE, PROBE, DONE.
- IDLE, start=1: trial←1<<(WIDTH-1), bit index←WIDTH-1; clear result/found/err; busy←1; go to PROBE.
- PROBE, cmp_valid=0: hold everything.
- PROBE, cmp_valid=1, verdict not one-hot (zero or ≥2 of lt/eq/gt): result←trial, err←1, go to DONE.
- eq: result←trial, found←1, go to DONE (early exit).
- gt: clear trial[bit]. lt: keep trial[bit].
- After a gt or lt decision:
  - If bit=0: result←updated trial, go to DONE.
  - Otherwise: set trial[bit-1] and decrement bit.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. trial holds its last value.
- Converged result = target for any integer target in 0..2^WIDTH-1. found=0 only when the search runs to bit 0 without an eq verdict (e.g. target 0).
- abort (any state, priority over cmp_valid/start): go to IDLE, busy←0, no done; result/found/err keep their prior values.
- start while busy: ignored.

## Timing
- Reset values: state IDLE, trial 0, result 0, busy 0, done 0, found 0, err 0.
- Reset asserted mid-search aborts immediately (asynchronous). The first start after release behaves normally.
- All outputs are registered. trial changes only on the clock edge after an accepted start or a consumed verdict. A combinational comparator may therefore answer in the same cycle trial is presented.
- With cmp_valid held high:
  - start sampled at edge 0.
  - Verdict k is consumed at edge k.
  - done is high in the cycle following the deciding edge.
  - Worst case WIDTH probes, then done. Best case 1 probe (target = 2^(WIDTH-1)).
- cmp_valid gaps add cycles 1:1. No verdict is ever lost or double-consumed.
- start and done may not coincide; start in the DONE cycle is ignored.

## Structure
- Shared package sar_pkg:
  - state enum (IDLE/PROBE/DONE)
  - 3-bit verdict encoding {gt,eq,lt}, with constants VERDICT_LT=3'b001, VERDICT_EQ=3'b010, VERDICT_GT=3'b100
  - function is_onehot3
- No sub-module. The comparator stays external so existing comparator blocks plug in unchanged.
- Bit index is a $clog2(WIDTH)-bit counter. Trial update is mask-based.

## Test plan
WIDTH=8 throughout, using a behavioural comparator with cmp_valid tied high unless stated.
- Target 100:
  - trials 128(gt), 64(lt), 96(lt), 112(gt), 104(gt), 100(eq)
  - done after 6th verdict, result=100, found=1, err=0
- Target 0: 8 gt verdicts, trial sequence 128,64,…,1 → result=0, found=0, done one cycle after 8th verdict.
- Target 255: trials 128,192,224,…,255 → eq on 8th probe, result=255, found=1.
- Target 37 with 3 idle cycles before each cmp_valid: trial stable through gaps, result=37, total latency = probes + gaps.
- Error case: first verdict with cmp_lt=cmp_gt=1 → result=128, err=1, done pulse. Second case: start pulsed while busy is ignored.
- Reset and abort:
  - rst_n low during probe 3: all outputs 0 immediately; next start on target 9 yields result=9.
  - abort mid-search: busy drops, no done, result unchanged.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller:
// FSM states, one-hot comparator verdict encoding and a one-hot helper.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        DONE
    } state_t;

    // Verdict bus layout is {gt, eq, lt}
    localparam logic [2:0] VERDICT_LT = 3'b001;
    localparam logic [2:0] VERDICT_EQ = 3'b010;
    localparam logic [2:0] VERDICT_GT = 3'b100;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == VERDICT_LT) || (v == VERDICT_EQ) || (v == VERDICT_GT);
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// MSB-first binary search against an external equal/less/greater comparator.
// All outputs come straight from flops; the comparator may answer combinationally.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] trial,
    input  logic             cmp_valid,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [WIDTH-1:0] trial_n, result_n, mask, decided;
    logic             busy_n, done_n, found_n, err_n;
    logic [2:0]       verdict;

    assign verdict = {cmp_gt, cmp_eq, cmp_lt};
    assign mask    = WIDTH'(1) << idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            trial  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            trial  <= trial_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
            found  <= found_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        trial_n  = trial;
        result_n = result;
        busy_n   = busy;
        done_n   = 1'b0;
        found_n  = found;
        err_n    = err;
        decided  = trial;

        if (abort) begin
            state_n = IDLE;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        trial_n  = {1'b1, {(WIDTH-1){1'b0}}};
                        idx_n    = IDX_W'(WIDTH - 1);
                        result_n = '0;
                        found_n  = 1'b0;
                        err_n    = 1'b0;
                        busy_n   = 1'b1;
                        state_n  = PROBE;
                    end
                end
                PROBE: begin
                    if (cmp_valid) begin
                        if (!is_onehot3(verdict)) begin
                            result_n = trial;
                            err_n    = 1'b1;
                            busy_n   = 1'b0;
                            done_n   = 1'b1;
                            state_n  = DONE;
                        end else if (verdict == VERDICT_EQ) begin
                            result_n = trial;
                            found_n  = 1'b1;
                            busy_n   = 1'b0;
                            done_n   = 1'b1;
                            state_n  = DONE;
                        end else begin
                            case (verdict)
                                VERDICT_GT: decided = trial & ~mask;
                                VERDICT_LT: decided = trial;
                                default:    decided = trial;
                            endcase
                            // Last bit decided: the trial itself is the answer
                            if (idx == '0) begin
                                trial_n  = decided;
                                result_n = decided;
                                busy_n   = 1'b0;
                                done_n   = 1'b1;
                                state_n  = DONE;
                            end else begin
                                trial_n = decided | (mask >> 1);
                                idx_n   = idx - 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

endmodule
